// File: rtl/cnn_layer_accel_prefetch_rd_seq_if.sv
// Control bundle between the prefetch read sequencer and its job
// controller, row buffer, fetch engine and downstream pixel consumer.
//   job_start/num_cols/num_rows : job launch and expanded window dims
//   cncl_fetch_req/row_ready    : buffer / fetch engine status
//   out_ready                   : downstream backpressure
//   fetch_req/rd_en/input_*     : buffer and fetch engine controls
//   next_row/rst_addr           : buffer row advance / address rewind
//   pix_valid/busy/job_done     : pixel qualifier and job status
interface cnn_layer_accel_prefetch_rd_seq_if #(
  parameter int C_CLG2_DEPTH = 10
);
  logic                    job_start;
  logic [C_CLG2_DEPTH-1:0] num_cols;
  logic [C_CLG2_DEPTH-1:0] num_rows;
  logic                    cncl_fetch_req;
  logic                    row_ready;
  logic                    out_ready;
  logic                    fetch_req;
  logic                    rd_en;
  logic [C_CLG2_DEPTH-1:0] input_col;
  logic [C_CLG2_DEPTH-1:0] input_row;
  logic                    next_row;
  logic                    rst_addr;
  logic                    pix_valid;
  logic                    busy;
  logic                    job_done;

  modport master (
    output job_start, num_cols, num_rows,
    output cncl_fetch_req, row_ready, out_ready,
    input  fetch_req, rd_en, input_col, input_row,
    input  next_row, rst_addr, pix_valid, busy, job_done
  );

  modport slave (
    input  job_start, num_cols, num_rows,
    input  cncl_fetch_req, row_ready, out_ready,
    output fetch_req, rd_en, input_col, input_row,
    output next_row, rst_addr, pix_valid, busy, job_done
  );
endinterface

// File: rtl/cnn_layer_accel_prefetch_rd_seq.sv
// Read-side sequencer for the prefetch row buffer: walks the expanded
// window row by row, requests or skips row fetches, streams pixels.
//   rd_clk : clock, all logic on posedge
//   rst    : synchronous active-high reset
//   bus    : job/buffer/stream bundle (slave view)
module cnn_layer_accel_prefetch_rd_seq #(
  parameter int C_CLG2_DEPTH = 10,
  parameter int C_RD_LATENCY = 2
) (
  input logic rd_clk,
  input logic rst,
  cnn_layer_accel_prefetch_rd_seq_if.slave bus
);
  localparam int DW = C_CLG2_DEPTH;
  localparam int CW = $clog2(C_RD_LATENCY + 1);
  localparam logic [DW-1:0] ONE = DW'(1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_ROW, STREAM, ROW_END, DRAIN, DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DW-1:0] cols_q;
  logic [DW-1:0] rows_q;
  logic [DW-1:0] col_q;
  logic [DW-1:0] row_q;
  logic [CW-1:0] drain_q;
  logic [C_RD_LATENCY-1:0] dly_q;
  logic [C_RD_LATENCY:0] dly_in;
  logic done_q;

  logic rd_en;
  logic fetch_req;
  logic rst_addr;
  logic next_row;
  logic col_last;
  logic row_last;
  logic dim_zero;
  logic drain_last;

  // Compare against num-1 so a full-range dimension never wraps.
  assign col_last = col_q == cols_q - ONE;
  assign row_last = row_q == rows_q - ONE;
  assign dim_zero = (bus.num_cols == '0) || (bus.num_rows == '0);
  assign drain_last = drain_q == CW'(C_RD_LATENCY - 1);

  always_ff @(posedge rd_clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (bus.job_start)
          state_d = dim_zero ? DONE : FETCH;
      FETCH:
        state_d = bus.cncl_fetch_req ? STREAM : WAIT_ROW;
      WAIT_ROW:
        if (bus.row_ready) state_d = STREAM;
      STREAM:
        if (rd_en && col_last) state_d = ROW_END;
      ROW_END:
        state_d = row_last ? DRAIN : FETCH;
      DRAIN:
        if (drain_last) state_d = DONE;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en     = 1'b0;
    fetch_req = 1'b0;
    rst_addr  = 1'b0;
    next_row  = 1'b0;
    unique case (state_q)
      FETCH: begin
        rst_addr  = bus.cncl_fetch_req;
        fetch_req = !bus.cncl_fetch_req;
      end
      STREAM:  rd_en = bus.out_ready;
      ROW_END: next_row = 1'b1;
      default: ;
    endcase
  end

  assign dly_in = {dly_q, rd_en};

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      cols_q  <= '0;
      rows_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      drain_q <= '0;
      dly_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      dly_q  <= dly_in[C_RD_LATENCY-1:0];
      done_q <= state_q == DONE;
      if (state_q == DRAIN) drain_q <= drain_q + CW'(1);
      else                  drain_q <= '0;
      if (state_q == IDLE && bus.job_start) begin
        cols_q <= bus.num_cols;
        rows_q <= bus.num_rows;
        col_q  <= '0;
        row_q  <= '0;
      end
      if (rd_en)
        col_q <= col_last ? '0 : col_q + ONE;
      if (state_q == ROW_END && !row_last)
        row_q <= row_q + ONE;
    end
  end

  assign bus.rd_en     = rd_en;
  assign bus.fetch_req = fetch_req;
  assign bus.rst_addr  = rst_addr;
  assign bus.next_row  = next_row;
  assign bus.input_col = col_q;
  assign bus.input_row = row_q;
  assign bus.pix_valid = dly_q[C_RD_LATENCY-1];
  assign bus.busy      = state_q != IDLE;
  assign bus.job_done  = done_q;
endmodule

// File: tb/tb_cnn_layer_accel_prefetch_rd_seq.sv
// Randomised bench for the prefetch read sequencer with a queue-based
// scoreboard of expected pixel positions and per-row fetch decisions.
module tb_cnn_layer_accel_prefetch_rd_seq;
  localparam int DW = 10;

  logic rd_clk = 1'b0;
  logic rst = 1'b1;
  always #5 rd_clk = ~rd_clk;

  cnn_layer_accel_prefetch_rd_seq_if #(.C_CLG2_DEPTH(DW)) bus ();

  cnn_layer_accel_prefetch_rd_seq #(
    .C_CLG2_DEPTH(DW),
    .C_RD_LATENCY(2)
  ) dut (
    .rd_clk(rd_clk),
    .rst(rst),
    .bus(bus)
  );

  logic [15:0] cncl_mask = '0;
  assign bus.cncl_fetch_req = cncl_mask[bus.input_row[3:0]];

  int n_cmp = 0;
  int n_fail = 0;

  int pq_row[$];
  int pq_col[$];
  int fq_row[$];
  bit fq_kind[$];
  int exp_total, exp_nr, cur_c, cur_r;
  bit in_job = 0;
  bit model_reset = 0;
  bit hit = 0;
  logic [1:0] hist = '0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int n_rd, n_pv, n_fetch, n_rsta, n_nr, n_done;
  int done_total = 0, fetch_total = 0;
  int prev_col, prev_row;
  bit prev_rd, prev_nr, prev_acc;

  int or_mode = 0, or_idx = 0;
  int rr_mode = 0, rr_fix = 1, rr_cnt = 0, env_fc = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Environment: downstream backpressure and fetch-engine row_ready.
  initial begin
    bus.out_ready = 1'b1;
    bus.row_ready = 1'b1;
    forever begin
      @(posedge rd_clk);
      #1;
      or_idx++;
      case (or_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = (or_idx % 4 == 0) || (or_idx % 4 == 3);
        default: bus.out_ready = 1'($urandom_range(1, 0));
      endcase
      if (rr_mode == 0) begin
        bus.row_ready = 1'b1;
      end else begin
        if (fetch_total != env_fc) begin
          env_fc = fetch_total;
          rr_cnt = (rr_mode == 1) ? rr_fix : int'($urandom_range(3, 0));
        end
        if (rr_cnt == 0) bus.row_ready = 1'b1;
        else begin
          bus.row_ready = 1'b0;
          rr_cnt--;
        end
      end
    end
  end

  // Scoreboard / compare process.
  always @(negedge rd_clk) begin
    cyc++;
    if (rst || model_reset) begin
      pq_row.delete();
      pq_col.delete();
      fq_row.delete();
      fq_kind.delete();
      in_job = 0;
      hist = '0;
      model_reset = 0;
      prev_rd = 0;
      prev_nr = 0;
      prev_acc = 0;
      prev_col = int'(bus.input_col);
      prev_row = int'(bus.input_row);
      env_fc = fetch_total;
    end else begin
      if (bus.job_done) begin
        chk("job_done_while_active", 32'(in_job), 1);
        chk("rd_en_total", n_rd, exp_total);
        chk("pix_valid_total", n_pv, exp_total);
        chk("pixels_left", pq_row.size(), 0);
        chk("fetch_decisions_left", fq_row.size(), 0);
        chk("next_row_total", n_nr, exp_nr);
        n_done++;
        done_total++;
        done_cyc = cyc;
        in_job = 0;
      end
      chk("busy", 32'(bus.busy), 32'(in_job));
      chk("pix_valid_delay", 32'(bus.pix_valid), 32'(hist[1]));
      hist = {hist[0], bus.rd_en};
      if (bus.pix_valid) n_pv++;
      if (bus.rd_en) begin
        chk("rd_en_needs_out_ready", 32'(bus.out_ready), 1);
        chk("rd_en_in_job", 32'(in_job), 1);
        if (pq_row.size() == 0) begin
          chk("rd_en_extra", 1, 0);
        end else begin
          chk("rd_row", bus.input_row, pq_row.pop_front());
          chk("rd_col", bus.input_col, pq_col.pop_front());
        end
        if (bus.input_row == 1 && bus.input_col == 2) hit = 1;
        n_rd++;
      end
      if (bus.fetch_req || bus.rst_addr) begin
        chk("fetch_and_rst_addr", 32'(bus.fetch_req & bus.rst_addr), 0);
        if (fq_row.size() == 0) begin
          chk("fetch_extra", 1, 0);
        end else begin
          chk("fetch_row", bus.input_row, fq_row.pop_front());
          chk("fetch_skip", 32'(bus.rst_addr), 32'(fq_kind.pop_front()));
        end
        if (bus.fetch_req) begin
          n_fetch++;
          fetch_total++;
        end
        if (bus.rst_addr) n_rsta++;
      end
      if (bus.next_row) begin
        chk("next_row_row", bus.input_row, n_nr);
        n_nr++;
      end
      if (!prev_acc) begin
        if (prev_rd)
          chk("col_step", bus.input_col,
              (prev_col + 1 == cur_c) ? 0 : prev_col + 1);
        else
          chk("col_hold", bus.input_col, prev_col);
        if (prev_nr && prev_row != cur_r - 1)
          chk("row_step", bus.input_row, prev_row + 1);
        else
          chk("row_hold", bus.input_row, prev_row);
      end
      prev_acc = bus.job_start && !in_job;
      if (prev_acc) begin
        in_job = 1;
        start_cyc = cyc;
        n_rd = 0; n_pv = 0; n_fetch = 0;
        n_rsta = 0; n_nr = 0; n_done = 0;
      end
      prev_rd = bus.rd_en;
      prev_nr = bus.next_row;
      prev_col = int'(bus.input_col);
      prev_row = int'(bus.input_row);
    end
  end

  task automatic start_job(input int c, input int r, input logic [15:0] m);
    cncl_mask = m;
    cur_c = c;
    cur_r = r;
    exp_total = c * r;
    exp_nr = (exp_total == 0) ? 0 : r;
    for (int i = 0; i < exp_nr; i++) begin
      fq_row.push_back(i);
      fq_kind.push_back(m[i[3:0]]);
      for (int j = 0; j < c; j++) begin
        pq_row.push_back(i);
        pq_col.push_back(j);
      end
    end
    @(posedge rd_clk);
    #1;
    bus.job_start = 1'b1;
    bus.num_cols = DW'(c);
    bus.num_rows = DW'(r);
    @(posedge rd_clk);
    #1;
    bus.job_start = 1'b0;
    bus.num_cols = DW'($urandom);
    bus.num_rows = DW'($urandom);
  endtask

  task automatic wait_done(input int bound, input int d0);
    for (int k = 0; k < bound; k++) begin
      @(negedge rd_clk);
      #1;
      if (done_total != d0) break;
    end
    chk("job_done_count", done_total - d0, 1);
    repeat (3) @(negedge rd_clk);
  endtask

  task automatic run_job(input int c, input int r, input logic [15:0] m,
                         input int orm, input int rrm);
    int d0;
    or_mode = orm;
    or_idx = 0;
    rr_mode = rrm;
    d0 = done_total;
    start_job(c, r, m);
    wait_done(100 + c * r * 12 + r * 30, d0);
  endtask

  initial begin
    int d0, f0, c, r;
    bus.job_start = 1'b0;
    bus.num_cols = '0;
    bus.num_rows = '0;
    repeat (4) @(posedge rd_clk);
    #1;
    rst = 1'b0;
    @(negedge rd_clk);
    #1;
    chk("reset_rd_en", 32'(bus.rd_en), 0);
    chk("reset_fetch_req", 32'(bus.fetch_req), 0);
    chk("reset_rst_addr", 32'(bus.rst_addr), 0);
    chk("reset_next_row", 32'(bus.next_row), 0);
    chk("reset_pix_valid", 32'(bus.pix_valid), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_job_done", 32'(bus.job_done), 0);
    chk("reset_input_row", bus.input_row, 0);
    chk("reset_input_col", bus.input_col, 0);

    rr_fix = 1;
    run_job(4, 3, 16'h0000, 0, 1);
    chk("basic_rd_en", n_rd, 12);
    chk("basic_pix_valid", n_pv, 12);
    chk("basic_fetch_req", n_fetch, 3);
    chk("basic_next_row", n_nr, 3);
    chk("basic_rst_addr", n_rsta, 0);
    chk("basic_job_done", n_done, 1);

    run_job(4, 3, 16'h0000, 1, 1);
    chk("bp_rd_en", n_rd, 12);
    chk("bp_pix_valid", n_pv, 12);

    run_job(3, 4, 16'b1010, 0, 1);
    chk("ups_fetch_req", n_fetch, 2);
    chk("ups_rst_addr", n_rsta, 2);
    chk("ups_next_row", n_nr, 4);

    run_job(4, 0, 16'h0000, 0, 1);
    chk("zero_rows_latency", done_cyc - start_cyc, 2);
    chk("zero_rows_rd_en", n_rd, 0);
    chk("zero_rows_fetch", n_fetch, 0);
    run_job(0, 3, 16'h0000, 0, 1);
    chk("zero_cols_latency", done_cyc - start_cyc, 2);
    chk("zero_cols_rd_en", n_rd, 0);

    run_job(2, 3, 16'h0000, 2, 0);

    hit = 0;
    or_mode = 0;
    rr_mode = 0;
    d0 = done_total;
    start_job(5, 3, 16'h0000);
    for (int k = 0; k < 200; k++) begin
      @(negedge rd_clk);
      #1;
      if (hit) break;
    end
    chk("reset_point_reached", 32'(hit), 1);
    rst = 1'b1;
    model_reset = 1;
    @(posedge rd_clk);
    #1;
    rst = 1'b0;
    @(negedge rd_clk);
    #1;
    chk("midrst_rd_en", 32'(bus.rd_en), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_pix_valid", 32'(bus.pix_valid), 0);
    chk("midrst_input_row", bus.input_row, 0);
    chk("midrst_input_col", bus.input_col, 0);
    chk("midrst_fetch_req", 32'(bus.fetch_req), 0);
    repeat (10) @(negedge rd_clk);
    chk("midrst_no_done", done_total - d0, 0);
    run_job(5, 3, 16'h0000, 0, 0);
    chk("post_rst_rd_en", n_rd, 15);

    or_mode = 0;
    rr_mode = 1;
    rr_fix = 3;
    d0 = done_total;
    f0 = fetch_total;
    start_job(3, 2, 16'h0000);
    for (int k = 0; k < 50; k++) begin
      @(negedge rd_clk);
      #1;
      if (fetch_total != f0) break;
    end
    chk("poke_fetch_seen", fetch_total - f0, 1);
    @(posedge rd_clk);
    #1;
    bus.job_start = 1'b1;
    bus.num_cols = DW'(7);
    bus.num_rows = DW'(7);
    @(posedge rd_clk);
    #1;
    bus.job_start = 1'b0;
    wait_done(300, d0);
    chk("poke_rd_en", n_rd, 6);
    repeat (10) @(negedge rd_clk);
    chk("poke_single_done", done_total - d0, 1);

    rr_fix = 1;
    run_job(1023, 1, 16'h0000, 0, 1);
    chk("max_cols_rd_en", n_rd, 1023);
    run_job(1, 3, 16'b0101, 0, 1);
    chk("one_col_rd_en", n_rd, 3);

    for (int j = 0; j < 8; j++) begin
      c = int'($urandom_range(6, 1));
      r = int'($urandom_range(5, 1));
      run_job(c, r, 16'($urandom), 2, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
